// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported 64-bit RAM between the fetch and load/store requesters.
// One transaction at a time: IDLE (grant) -> ACCESS (RD_LATENCY cycles) -> RESP (one-cycle ack).
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [63:0]       d_wdata,
    output logic              d_ack,
    output logic [63:0]       d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic              mem_we,
    input  logic [63:0]       mem_rdata,
    output logic              busy
);

    localparam int CNT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             last_data_reg;
    logic             gnt_data_reg;
    logic             store_reg;
    logic             sel_reg;
    logic             grant_data;

    // Data wins when it is the only requester, or on contention when fetch was served last.
    assign grant_data = d_req & (~i_req | ~last_data_reg);
    assign busy       = (state_reg != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            last_data_reg <= 1'b1;
            gnt_data_reg  <= 1'b0;
            store_reg     <= 1'b0;
            sel_reg       <= 1'b0;
            i_ack         <= 1'b0;
            d_ack         <= 1'b0;
            i_rdata       <= '0;
            d_rdata       <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_we        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_req || d_req) begin
                        gnt_data_reg <= grant_data;
                        if (i_req && d_req) begin
                            last_data_reg <= grant_data;
                        end
                        sel_reg   <= i_addr[2];
                        cnt_reg   <= CNT_LOAD;
                        state_reg <= ACCESS;
                        if (grant_data) begin
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_we    <= d_we;
                            store_reg <= d_we;
                        end else begin
                            mem_addr  <= i_addr;
                            mem_we    <= 1'b0;
                            store_reg <= 1'b0;
                        end
                    end
                end
                ACCESS: begin
                    // The write strobe only covers the first ACCESS cycle.
                    mem_we <= 1'b0;
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else begin
                        state_reg <= RESP;
                        if (gnt_data_reg) begin
                            d_ack <= 1'b1;
                            if (!store_reg) begin
                                d_rdata <= mem_rdata;
                            end
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= sel_reg ? mem_rdata[63:32] : mem_rdata[31:0];
                        end
                    end
                end
                RESP: begin
                    i_ack     <= 1'b0;
                    d_ack     <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
